// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state and mux-select encodings for the n-way cache controller.
// Rev 1.0
`default_nettype none

package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    CHECK   = 3'd0,
    WB      = 3'd1,
    FILL    = 3'd2,
    FL_SCAN = 3'd3,
    FL_WB   = 3'd4,
    FL_DONE = 3'd5
  } state_e;

  localparam logic [1:0] ADDR_CPU    = 2'b00;
  localparam logic [1:0] ADDR_WB_TAG = 2'b01;
  localparam logic [1:0] ADDR_FLUSH  = 2'b10;

  localparam logic [1:0] CIN_NONE = 2'b00;
  localparam logic [1:0] CIN_BUS  = 2'b10;
  localparam logic [1:0] CIN_LINE = 2'b11;

endpackage

`default_nettype wire

// File: rtl/cache_ctrl_nway_plru.sv
// plru_tree: per-set tree pseudo-LRU storage with update and victim lookup.
// Rev 1.0
`default_nettype none

module plru_tree #(
  parameter int num_ways = 4,
  parameter int num_sets = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        update,
  input  logic [$clog2(num_sets)-1:0] upd_index,
  input  logic [$clog2(num_ways)-1:0] upd_way,
  input  logic [$clog2(num_sets)-1:0] vic_index,
  output logic [$clog2(num_ways)-1:0] victim
);

  localparam int LVLS = $clog2(num_ways);

  // Heap-ordered nodes 1..num_ways-1; a 0 bit steers the victim toward the lower half.
  logic [num_ways-1:1] tree_q [num_sets];
  logic [num_ways-1:1] tree_d [num_sets];

  logic [LVLS-1:0]     upd_node;
  logic [LVLS-1:0]     upd_path;
  logic [LVLS-1:0]     vic_node;
  logic [LVLS-1:0]     vic_way;
  logic [num_ways-1:1] vic_bits;

  always_comb begin
    tree_d   = tree_q;
    upd_node = LVLS'(1);
    upd_path = upd_way;
    if (update) begin
      for (int l = 0; l < LVLS; l++) begin
        tree_d[upd_index][upd_node] = ~upd_path[LVLS-1];
        upd_node    = upd_node << 1;
        upd_node[0] = upd_path[LVLS-1];
        upd_path    = upd_path << 1;
      end
    end
  end

  always_comb begin
    vic_bits = tree_q[vic_index];
    vic_node = LVLS'(1);
    vic_way  = '0;
    for (int l = 0; l < LVLS; l++) begin
      vic_way     = vic_way << 1;
      vic_way[0]  = vic_bits[vic_node];
      vic_node    = vic_node << 1;
      vic_node[0] = vic_way[0];
    end
    victim = vic_way;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tree_q <= '{default: '0};
    end else begin
      tree_q <= tree_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: n-way write-back cache controller with PLRU replacement and flush.
// Rev 1.0
`default_nettype none

module cache_ctrl_nway
  import cache_ctrl_pkg::*;
#(
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_way    = $clog2(num_ways)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [s_index-1:0]  mem_index,
  input  logic                flush_req,
  input  logic [num_ways-1:0] hit_vec,
  input  logic [num_ways-1:0] valid_vec,
  input  logic [num_ways-1:0] dirty_vec,
  input  logic                cl_resp,
  output logic                mem_resp,
  output logic                flush_done,
  output logic [num_ways-1:0] way_sel,
  output logic [1:0]          addr_sel,
  output logic [s_index-1:0]  flush_index,
  output logic [1:0]          cache_in_sel,
  output logic                set_dirty,
  output logic                clr_dirty,
  output logic                set_valid_tag,
  output logic                cl_read,
  output logic                cl_write
);

  localparam int                NUM_SETS = 2 ** s_index;
  localparam logic [num_ways-1:0] WAY_ONE = {{(num_ways-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [s_way-1:0]   victim_q, victim_d;
  logic [s_way-1:0]   way_cnt_q, way_cnt_d;
  logic [s_index-1:0] set_cnt_q, set_cnt_d;

  logic [s_way-1:0]   hit_way, inv_way, plru_victim, miss_way;
  logic               req, any_hit, any_inv, plru_update, flush_last;

  assign req        = mem_read | mem_write;
  assign any_hit    = |hit_vec;
  assign any_inv    = ~(&valid_vec);
  assign miss_way   = any_inv ? inv_way : plru_victim;
  assign flush_last = (&set_cnt_q) & (&way_cnt_q);

  // Descending scan so the lowest-numbered match wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = num_ways - 1; i >= 0; i--) begin
      if (hit_vec[i])    hit_way = s_way'(i);
      if (!valid_vec[i]) inv_way = s_way'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    way_cnt_d     = way_cnt_q;
    set_cnt_d     = set_cnt_q;
    plru_update   = 1'b0;
    mem_resp      = 1'b0;
    flush_done    = 1'b0;
    way_sel       = '0;
    addr_sel      = ADDR_CPU;
    flush_index   = '0;
    cache_in_sel  = CIN_NONE;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    set_valid_tag = 1'b0;
    cl_read       = 1'b0;
    cl_write      = 1'b0;

    // Outputs stay quiet for as long as reset is held, not just after the next edge.
    if (rst) begin
      case (state_q)
        CHECK: begin
          if (req) begin
            if (any_hit) begin
              mem_resp    = 1'b1;
              way_sel     = WAY_ONE << hit_way;
              plru_update = 1'b1;
              if (mem_write) begin
                cache_in_sel = CIN_BUS;
                set_dirty    = 1'b1;
              end
            end else begin
              victim_d = miss_way;
              state_d  = (valid_vec[miss_way] & dirty_vec[miss_way]) ? WB : FILL;
            end
          end else if (flush_req) begin
            set_cnt_d = '0;
            way_cnt_d = '0;
            state_d   = FL_SCAN;
          end
        end
        WB: begin
          cl_write = 1'b1;
          addr_sel = ADDR_WB_TAG;
          way_sel  = WAY_ONE << victim_q;
          if (cl_resp) begin
            clr_dirty = 1'b1;
            state_d   = FILL;
          end
        end
        FILL: begin
          cl_read      = 1'b1;
          cache_in_sel = CIN_LINE;
          way_sel      = WAY_ONE << victim_q;
          if (cl_resp) begin
            set_valid_tag = 1'b1;
            state_d       = CHECK;
          end
        end
        FL_SCAN: begin
          addr_sel    = ADDR_FLUSH;
          flush_index = set_cnt_q;
          way_sel     = WAY_ONE << way_cnt_q;
          if (valid_vec[way_cnt_q] & dirty_vec[way_cnt_q]) begin
            state_d = FL_WB;
          end else if (flush_last) begin
            state_d = FL_DONE;
          end else begin
            way_cnt_d = way_cnt_q + 1'b1;
            if (&way_cnt_q) set_cnt_d = set_cnt_q + 1'b1;
          end
        end
        FL_WB: begin
          cl_write    = 1'b1;
          addr_sel    = ADDR_FLUSH;
          flush_index = set_cnt_q;
          way_sel     = WAY_ONE << way_cnt_q;
          if (cl_resp) begin
            clr_dirty = 1'b1;
            if (flush_last) begin
              state_d = FL_DONE;
            end else begin
              way_cnt_d = way_cnt_q + 1'b1;
              if (&way_cnt_q) set_cnt_d = set_cnt_q + 1'b1;
              state_d = FL_SCAN;
            end
          end
        end
        FL_DONE: begin
          flush_done = 1'b1;
          set_cnt_d  = '0;
          way_cnt_d  = '0;
          state_d    = CHECK;
        end
        default: state_d = CHECK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CHECK;
      victim_q  <= '0;
      way_cnt_q <= '0;
      set_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      way_cnt_q <= way_cnt_d;
      set_cnt_q <= set_cnt_d;
    end
  end

  plru_tree #(
    .num_ways (num_ways),
    .num_sets (NUM_SETS)
  ) u_plru (
    .clk       (clk),
    .rst       (rst),
    .update    (plru_update),
    .upd_index (mem_index),
    .upd_way   (hit_way),
    .vic_index (mem_index),
    .victim    (plru_victim)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl_nway.sv
// tb_cache_ctrl_nway: directed self-checking bench for cache_ctrl_nway (8 sets, 4 ways).
// Rev 1.0
`default_nettype none

module tb_cache_ctrl_nway;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write, flush_req, cl_resp;
  logic [2:0] mem_index;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic       mem_resp, flush_done, set_dirty, clr_dirty, set_valid_tag, cl_read, cl_write;
  logic [3:0] way_sel;
  logic [1:0] addr_sel, cache_in_sel;
  logic [2:0] flush_index;

  logic [17:0] obs;
  logic [17:0] exp_v;
  int          n_cmp = 0;
  int          n_err = 0;
  int          s, w, ph, n_wb;
  logic        prev_clw;

  cache_ctrl_nway dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_index     (mem_index),
    .flush_req     (flush_req),
    .hit_vec       (hit_vec),
    .valid_vec     (valid_vec),
    .dirty_vec     (dirty_vec),
    .cl_resp       (cl_resp),
    .mem_resp      (mem_resp),
    .flush_done    (flush_done),
    .way_sel       (way_sel),
    .addr_sel      (addr_sel),
    .flush_index   (flush_index),
    .cache_in_sel  (cache_in_sel),
    .set_dirty     (set_dirty),
    .clr_dirty     (clr_dirty),
    .set_valid_tag (set_valid_tag),
    .cl_read       (cl_read),
    .cl_write      (cl_write)
  );

  always #5 clk = ~clk;

  assign obs = {mem_resp, flush_done, way_sel, addr_sel, flush_index, cache_in_sel,
                set_dirty, clr_dirty, set_valid_tag, cl_read, cl_write};

  function automatic logic [17:0] pk(input logic r, input logic fd, input logic [3:0] ws,
                                     input logic [1:0] as, input logic [2:0] fi,
                                     input logic [1:0] ci, input logic sd, input logic cd,
                                     input logic sv, input logic cr, input logic cw);
    return {r, fd, ws, as, fi, ci, sd, cd, sv, cr, cw};
  endfunction

  function automatic logic [3:0] oh(input int k);
    return 4'b0001 << k;
  endfunction

  task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
    n_cmp++;
    assert (o === e)
    else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; flush_req = 1'b0; cl_resp = 1'b0;
    mem_index = 3'd2; hit_vec = 4'b0010; valid_vec = 4'hF; dirty_vec = 4'h0;
    #2;
    chk("reset_outputs_zero", obs, 18'h0);
    tick(); tick();
    rst = 1'b1; mem_read = 1'b0; hit_vec = 4'h0;
    @(negedge clk);
    chk("idle_after_reset", obs, 18'h0);

    // Read hit on way 1, then a miss in the same set must not victimise way 1.
    tick(); mem_index = 3'd2; mem_read = 1'b1; hit_vec = 4'b0010;
    @(negedge clk);
    chk("hit_way1", obs, pk(1'b1, 1'b0, 4'b0010, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); hit_vec = 4'h0;
    @(negedge clk);
    chk("miss_set2", obs, 18'h0);
    tick();
    @(negedge clk);
    chk("fill_not_way1", obs, pk(1'b0, 1'b0, 4'b0100, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); cl_resp = 1'b1;
    @(negedge clk);
    chk("fill_resp_set2", obs, pk(1'b0, 1'b0, 4'b0100, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tick(); cl_resp = 1'b0; hit_vec = 4'b0100;
    @(negedge clk);
    chk("recheck_set2", obs, pk(1'b1, 1'b0, 4'b0100, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Dirty victim: WB then FILL with 5-cycle adapter, read+write treated as write.
    tick(); mem_index = 3'd5; mem_read = 1'b1; mem_write = 1'b1; hit_vec = 4'h0;
    valid_vec = 4'hF; dirty_vec = 4'b0001;
    @(negedge clk);
    chk("miss_set5_dirty", obs, 18'h0);
    for (int c = 1; c <= 13; c++) begin
      tick();
      cl_resp = (c == 6 || c == 12);
      hit_vec = (c == 13) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (c <= 6)
        exp_v = pk(1'b0, 1'b0, 4'b0001, 2'b01, 3'd0, 2'b00, 1'b0, (c == 6), 1'b0, 1'b0, 1'b1);
      else if (c <= 12)
        exp_v = pk(1'b0, 1'b0, 4'b0001, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0, (c == 12), 1'b1, 1'b0);
      else
        exp_v = pk(1'b1, 1'b0, 4'b0001, 2'b00, 3'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("wb_fill_c%0d", c), obs, exp_v);
    end
    tick(); mem_read = 1'b0; mem_write = 1'b0; cl_resp = 1'b0; hit_vec = 4'h0; dirty_vec = 4'h0;

    // Invalid way 2 is chosen and filled directly even though its dirty bit is set.
    tick(); mem_index = 3'd3; mem_read = 1'b1; valid_vec = 4'b1011; dirty_vec = 4'hF;
    @(negedge clk);
    chk("miss_set3", obs, 18'h0);
    tick();
    @(negedge clk);
    chk("fill_invalid_way2", obs, pk(1'b0, 1'b0, 4'b0100, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); cl_resp = 1'b1;
    @(negedge clk);
    chk("fill_resp_set3", obs, pk(1'b0, 1'b0, 4'b0100, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tick(); cl_resp = 1'b0; valid_vec = 4'hF; dirty_vec = 4'h0; hit_vec = 4'b0100;
    @(negedge clk);
    chk("recheck_set3", obs, pk(1'b1, 1'b0, 4'b0100, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Write and flush together: write served first, flush accepted on the idle cycle.
    tick(); mem_index = 3'd1; mem_read = 1'b0; mem_write = 1'b1; flush_req = 1'b1; hit_vec = 4'b1000;
    @(negedge clk);
    chk("write_before_flush", obs, pk(1'b1, 1'b0, 4'b1000, 2'b00, 3'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); mem_write = 1'b0; hit_vec = 4'h0;
    @(negedge clk);
    chk("flush_accept_idle", obs, 18'h0);

    // Walk the flush; a pending read must wait; dirty lines at set0/way3 and set7/way0.
    ph = 0; s = 0; w = 0; n_wb = 0; prev_clw = 1'b0;
    for (int c = 0; c < 200 && ph != 4; c++) begin
      tick();
      mem_read = 1'b1; mem_index = 3'd4; hit_vec = 4'b0001; valid_vec = 4'hF;
      dirty_vec = (s == 0) ? 4'b1000 : ((s == 7) ? 4'b0001 : 4'b0000);
      cl_resp = (ph == 2);
      @(negedge clk);
      if (cl_write && !prev_clw) n_wb++;
      prev_clw = cl_write;
      case (ph)
        0:       exp_v = pk(1'b0, 1'b0, oh(w), 2'b10, 3'(s), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        1:       exp_v = pk(1'b0, 1'b0, oh(w), 2'b10, 3'(s), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        2:       exp_v = pk(1'b0, 1'b0, oh(w), 2'b10, 3'(s), 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        default: exp_v = pk(1'b0, 1'b1, 4'b0000, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
      chk($sformatf("flush_s%0d_w%0d_ph%0d", s, w, ph), obs, exp_v);
      case (ph)
        0: begin
          if (dirty_vec[w]) ph = 1;
          else if (s == 7 && w == 3) ph = 3;
          else if (w == 3) begin w = 0; s++; end
          else w++;
        end
        1: ph = 2;
        2: begin
          if (s == 7 && w == 3) ph = 3;
          else begin
            if (w == 3) begin w = 0; s++; end
            else w++;
            ph = 0;
          end
        end
        default: ph = 4;
      endcase
    end
    tick(); flush_req = 1'b0; cl_resp = 1'b0;
    @(negedge clk);
    chk("read_after_flush", obs, pk(1'b1, 1'b0, 4'b0001, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("flush_wb_count", 18'(n_wb), 18'd2);

    // Set 5 PLRU points at way 2 now; reset mid-FILL must clear it back to way 0.
    tick(); mem_index = 3'd5; mem_read = 1'b1; hit_vec = 4'h0; dirty_vec = 4'h0;
    @(negedge clk);
    chk("miss_set5_pre_rst", obs, 18'h0);
    tick();
    @(negedge clk);
    chk("fill_set5_way2", obs, pk(1'b0, 1'b0, 4'b0100, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    #1 rst = 1'b0;
    #1;
    chk("async_rst_mid_fill", obs, 18'h0);
    tick(); tick();
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    chk("idle_after_rst2", obs, 18'h0);
    for (int k = 0; k < 2; k++) begin
      tick(); mem_index = (k == 0) ? 3'd5 : 3'd4; mem_read = 1'b1;
      @(negedge clk);
      chk($sformatf("miss_post_rst_%0d", k), obs, 18'h0);
      tick();
      @(negedge clk);
      chk($sformatf("fill_way0_post_rst_%0d", k), obs,
          pk(1'b0, 1'b0, 4'b0001, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      tick(); cl_resp = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      chk($sformatf("fill_resp_post_rst_%0d", k), obs,
          pk(1'b0, 1'b0, 4'b0001, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      tick(); cl_resp = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_ctrl_nway.md
CACHE_CTRL_NWAY -- requirements
Module: cache_ctrl_nway

Interface
REQ-001 SHALL have parameter s_index, default 3, meaning set-index width; num_sets = 2**s_index.
REQ-002 SHALL have parameter num_ways, default 4, meaning associativity; a power of two, at least 2.
REQ-003 SHALL have parameter s_way, default $clog2(num_ways), meaning way-number width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 mem_read, mem_write  input  1 each  CPU request, held until mem_resp.
REQ-007 mem_index  input  s_index  set index of the CPU address.
REQ-008 flush_req  input  1  write-back-all request, held until flush_done.
REQ-009 hit_vec, valid_vec, dirty_vec  input  num_ways each  per-way tag match, valid and dirty bits of the currently addressed set.
REQ-010 cl_resp  input  1  line-adapter completion.
REQ-011 mem_resp, flush_done  output  1 each  one-cycle completion pulses.
REQ-012 way_sel  output  num_ways  one-hot way for data/meta access.
REQ-013 addr_sel  output  2  address source: 00 CPU, 01 write-back tag, 10 flush counter.
REQ-014 flush_index  output  s_index  set addressed during flush.
REQ-015 cache_in_sel  output  2  data source: 00 none, 10 bus adapter, 11 line adapter.
REQ-016 set_dirty, clr_dirty, set_valid_tag  output  1 each  metadata write strobes, applied to way_sel.
REQ-017 cl_read, cl_write  output  1 each  line-adapter requests, held until cl_resp.

Function
REQ-018 States SHALL be CHECK, WB, FILL, FL_SCAN, FL_WB and FL_DONE.
REQ-019 CHECK, request and any hit_vec bit: mem_resp=1 the same cycle; way_sel = lowest set hit bit; on write, cache_in_sel=10 and set_dirty=1; PLRU of mem_index updated toward the hit way; stay in CHECK.
REQ-020 CHECK, request and no hit: victim = lowest-numbered invalid way, else the PLRU victim; victim latched.
REQ-021 After REQ-020, next state SHALL be WB if the victim is valid and dirty, else FILL.
REQ-022 WB: cl_write=1, addr_sel=01, way_sel=victim; on cl_resp, clr_dirty=1 and go to FILL.
REQ-023 FILL: cl_read=1, cache_in_sel=11, way_sel=victim; on cl_resp, set_valid_tag=1 and go to CHECK.
REQ-024 The re-check after FILL SHALL hit; miss-to-resp latency = 2 + adapter cycles (FILL only) or 3 + both adapter latencies (WB+FILL).
REQ-025 mem_read and mem_write both high SHALL be treated as a write.
REQ-026 Requests SHALL have priority over flush; flush_req is accepted in CHECK only when mem_read=mem_write=0.
REQ-027 Flush acceptance SHALL clear the set/way counter and go to FL_SCAN.
REQ-028 FL_SCAN: addr_sel=10, flush_index=set counter, way_sel=way counter.
REQ-029 FL_SCAN: if that way is valid and dirty, go to FL_WB; else advance the counter (way first, then set).
REQ-030 FL_SCAN: at set num_sets-1, way num_ways-1 with nothing to write, go to FL_DONE.
REQ-031 FL_WB: cl_write=1, addr_sel=10; on cl_resp, clr_dirty=1, advance the counter, return to FL_SCAN, or go to FL_DONE if last.
REQ-032 FL_DONE: flush_done=1 for one cycle, then CHECK; the counter wraps to 0.
REQ-033 CPU requests arriving during a flush SHALL wait; mem_resp stays 0 until return to CHECK.
REQ-034 Tree-PLRU SHALL hold num_ways-1 bits per set; an update points every node on the accessed path away from the accessed way; the victim follows the node bits.
REQ-035 PLRU SHALL NOT update on fill or flush.
REQ-036 Any output not driven by the current state SHALL be 0; way_sel=0 in idle CHECK.

Reset
REQ-037 rst low SHALL immediately force state CHECK, all PLRU bits 0, counters 0 and victim 0.
REQ-038 rst low SHALL immediately force every output 0, including mid-WB/FILL/flush; the interrupted transaction is abandoned.

Structure
REQ-039 Package cache_ctrl_pkg SHALL hold the state enum plus addr_sel and cache_in_sel encodings.
REQ-040 Sub-module plru_tree (parameters num_ways, num_sets; ports update, upd_index, upd_way, vic_index, victim) SHALL hold the PLRU storage.

Verification
REQ-041 Read with hit_vec=0010 -> mem_resp=1 same cycle, way_sel=0010; next miss in the same set with all ways valid never picks way 1.
REQ-042 Miss, valid_vec=1111, dirty on victim, cl_resp after 5 cycles each -> WB, clr_dirty, FILL, set_valid_tag, hit; mem_resp at cycle 13.
REQ-043 Miss with valid_vec=1011 -> victim way 2, direct FILL, no cl_write.
REQ-044 Flush with dirty lines only at set 0 way 3 and set 7 way 0 -> exactly two write-backs, flush_done after the counter reaches set 7 way 3.
REQ-045 flush_req and mem_write together -> write served first, flush starts the next idle cycle.
REQ-046 rst low during FILL with cl_read=1 -> cl_read=0 immediately; after release, state CHECK and PLRU victim of every set = way 0.
